inst_fetch_queue: RTL and testbench

//  Dual-issue instruction queue between fetch and the two-slot decoder.
//  - Accepts up to 2 fetched {pc, inst} pairs per cycle.
//  - Presents the oldest 2 entries as inst[1:0] / pc[1:0] to the decoder.
//  - Retires up to 2 entries per cycle as decode takes them.
//  - Discards all contents on a branch/jump redirect (flush).

---
 rtl/inst_fetch_queue_pkg.sv | 21 ++
 rtl/inst_fetch_queue_storage.sv | 32 +++
 rtl/inst_fetch_queue.sv | 131 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the dual-issue instruction fetch queue.
package inst_fetch_queue_pkg;

   localparam int unsigned IFQ_WIDTH = 32;
   localparam int unsigned IFQ_DEPTH = 8;

   localparam logic [IFQ_WIDTH-1:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [IFQ_WIDTH-1:0] pc;
      logic [IFQ_WIDTH-1:0] inst;
   } ifq_entry_t;

   localparam int unsigned IFQ_ENTRY_W = $bits(ifq_entry_t);

   // Number of set bits in a 2-bit thermometer/handshake vector.
   function automatic logic [1:0] pop2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/inst_fetch_queue_storage.sv
// Entry array for the fetch queue: two write ports, two asynchronous read ports.
module inst_fetch_queue_storage
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IFQ_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                   i_clk,
   input  logic                   i_we0,
   input  logic [AW-1:0]          i_waddr0,
   input  logic [IFQ_ENTRY_W-1:0] i_wdata0,
   input  logic                   i_we1,
   input  logic [AW-1:0]          i_waddr1,
   input  logic [IFQ_ENTRY_W-1:0] i_wdata1,
   input  logic [AW-1:0]          i_raddr0,
   input  logic [AW-1:0]          i_raddr1,
   output logic [IFQ_ENTRY_W-1:0] o_rdata0_c,
   output logic [IFQ_ENTRY_W-1:0] o_rdata1_c
);

   ifq_entry_t r_mem [DEPTH];

   // Data array needs no reset; validity is tracked by the queue pointers.
   always_ff @(posedge i_clk) begin
      if (i_we0) r_mem[i_waddr0] <= ifq_entry_t'(i_wdata0);
      if (i_we1) r_mem[i_waddr1] <= ifq_entry_t'(i_wdata1);
   end

   assign o_rdata0_c = r_mem[i_raddr0];
   assign o_rdata1_c = r_mem[i_raddr1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue between fetch and a two-slot decoder.
// Pointers, occupancy, handshake checking and flush live here; data lives in storage.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IFQ_DEPTH
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic [1:0]               i_enq_valid,
   input  logic [2*IFQ_WIDTH-1:0]   i_enq_inst,
   input  logic [2*IFQ_WIDTH-1:0]   i_enq_pc,
   output logic                     o_enq_ready,
   output logic [1:0]               o_deq_valid,
   output logic [2*IFQ_WIDTH-1:0]   o_deq_inst,
   output logic [2*IFQ_WIDTH-1:0]   o_deq_pc,
   input  logic [1:0]               i_deq_take,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned W  = IFQ_WIDTH;

   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          r_err;

   logic          w_enq_bad;
   logic          w_deq_bad;
   logic          w_enq_ready;
   logic [1:0]    w_deq_valid;
   logic [CW-1:0] w_n_enq;
   logic [CW-1:0] w_n_deq;
   logic          w_we0;
   logic          w_we1;
   ifq_entry_t    w_wentry0;
   ifq_entry_t    w_wentry1;
   ifq_entry_t    w_slot0;
   ifq_entry_t    w_slot1;
   logic [IFQ_ENTRY_W-1:0] w_rdata0;
   logic [IFQ_ENTRY_W-1:0] w_rdata1;

   // Readiness reserves room for a full pair so no partial accept is ever needed.
   assign w_enq_ready = (r_count <= CW'(DEPTH - 2));

   always_comb begin
      w_deq_valid = 2'b00;
      if (r_count >= CW'(2))      w_deq_valid = 2'b11;
      else if (r_count == CW'(1)) w_deq_valid = 2'b01;
   end

   assign w_enq_bad = (i_enq_valid == 2'b10);
   assign w_deq_bad = (i_deq_take == 2'b10) || ((i_deq_take & ~w_deq_valid) != 2'b00);

   assign w_n_enq = (w_enq_ready && !w_enq_bad) ? CW'(pop2(i_enq_valid)) : '0;
   assign w_n_deq = (!w_deq_bad) ? CW'(pop2(i_deq_take)) : '0;

   assign w_we0 = !i_rst && !i_flush && (w_n_enq != '0);
   assign w_we1 = !i_rst && !i_flush && (w_n_enq == CW'(2));

   always_comb begin
      w_wentry0.pc   = i_enq_pc[W-1:0];
      w_wentry0.inst = i_enq_inst[W-1:0];
      w_wentry1.pc   = i_enq_pc[2*W-1:W];
      w_wentry1.inst = i_enq_inst[2*W-1:W];
   end

   inst_fetch_queue_storage #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_storage (
      .i_clk      (i_clk),
      .i_we0      (w_we0),
      .i_waddr0   (r_wr_ptr),
      .i_wdata0   (w_wentry0),
      .i_we1      (w_we1),
      .i_waddr1   (AW'(r_wr_ptr + AW'(1))),
      .i_wdata1   (w_wentry1),
      .i_raddr0   (r_rd_ptr),
      .i_raddr1   (AW'(r_rd_ptr + AW'(1))),
      .o_rdata0_c (w_rdata0),
      .o_rdata1_c (w_rdata1)
   );

   assign w_slot0 = ifq_entry_t'(w_rdata0);
   assign w_slot1 = ifq_entry_t'(w_rdata1);

   // Slots without a live entry present a harmless NOP at pc 0.
   always_comb begin
      o_deq_inst = {NOP_INST, NOP_INST};
      o_deq_pc   = '0;
      if (w_deq_valid[0]) begin
         o_deq_inst[W-1:0] = w_slot0.inst;
         o_deq_pc[W-1:0]   = w_slot0.pc;
      end
      if (w_deq_valid[1]) begin
         o_deq_inst[2*W-1:W] = w_slot1.inst;
         o_deq_pc[2*W-1:W]   = w_slot1.pc;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_err <= w_enq_bad | w_deq_bad;
         if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n_enq);
            r_rd_ptr <= r_rd_ptr + AW'(w_n_deq);
            r_count  <= r_count + w_n_enq - w_n_deq;
         end
      end
   end

   assign o_enq_ready = w_enq_ready;
   assign o_deq_valid = w_deq_valid;
   assign o_count     = r_count;
   assign o_err       = r_err;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: stimulus pushes expected PCs, a monitor checks deq slots.
module tb_inst_fetch_queue;
   import inst_fetch_queue_pkg::*;

   localparam int unsigned W = IFQ_WIDTH;

   logic           clk = 1'b0;
   logic           rst;
   logic           flush;
   logic [1:0]     enq_valid;
   logic [2*W-1:0] enq_inst;
   logic [2*W-1:0] enq_pc;
   logic           enq_ready;
   logic [1:0]     deq_valid;
   logic [2*W-1:0] deq_inst;
   logic [2*W-1:0] deq_pc;
   logic [1:0]     deq_take;
   logic [3:0]     count;
   logic           err;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   inst_fetch_queue #(.DEPTH(8)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_flush     (flush),
      .i_enq_valid (enq_valid),
      .i_enq_inst  (enq_inst),
      .i_enq_pc    (enq_pc),
      .o_enq_ready (enq_ready),
      .o_deq_valid (deq_valid),
      .o_deq_inst  (deq_inst),
      .o_deq_pc    (deq_pc),
      .i_deq_take  (deq_take),
      .o_count     (count),
      .o_err       (err)
   );

   function automatic logic [31:0] mk_inst(input logic [31:0] pc);
      return {16'hC0DE, pc[15:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle; after the edge record which PCs the queue should now hold.
   task automatic step(input logic [1:0] ev, input logic [31:0] pc0, input logic [1:0] take,
                       input logic fl, input int push);
      logic [31:0] pc1;
      pc1       = pc0 + 32'd4;
      enq_valid = ev;
      enq_pc    = {pc1, pc0};
      enq_inst  = {mk_inst(pc1), mk_inst(pc0)};
      deq_take  = take;
      flush     = fl;
      @(posedge clk);
      if (fl) exp_q.delete();
      for (int k = 0; k < push; k++) exp_q.push_back(pc0 + 32'(4 * k));
      #1;
   endtask

   // Monitor: every presented slot must match the scoreboard; legal takes retire entries.
   initial begin : monitor
      logic [31:0] apc;
      logic [31:0] ain;
      int          npop;
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int s = 0; s < 2; s++) begin
               apc = deq_pc[s*32 +: 32];
               ain = deq_inst[s*32 +: 32];
               if (deq_valid[s]) begin
                  if (exp_q.size() > s) begin
                     check($sformatf("deq_pc[%0d]", s), 64'(apc), 64'(exp_q[s]));
                     check($sformatf("deq_inst[%0d]", s), 64'(ain), 64'(mk_inst(exp_q[s])));
                  end else begin
                     n_vec++;
                     n_bad++;
                     $display("FAIL deq_extra[%0d]: got pc %0h expected no entry", s, apc);
                  end
               end else begin
                  check($sformatf("idle_pc[%0d]", s), 64'(apc), 64'(0));
                  check($sformatf("idle_inst[%0d]", s), 64'(ain), 64'(NOP_INST));
               end
            end
            if (deq_take != 2'b10 && (deq_take & ~deq_valid) == 2'b00) begin
               npop = int'(deq_take[0]) + int'(deq_take[1]);
               for (int k = 0; k < npop; k++)
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected $finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst       = 1'b1;
      flush     = 1'b0;
      enq_valid = 2'b00;
      enq_inst  = '0;
      enq_pc    = '0;
      deq_take  = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_count", 64'(count), 64'(0));
      check("rst_valid", 64'(deq_valid), 64'(0));
      check("rst_ready", 64'(enq_ready), 64'(1));
      check("rst_err", 64'(err), 64'(0));
      check("rst_inst", deq_inst, {NOP_INST, NOP_INST});

      // Fill to full
      step(2'b11, 32'h00, 2'b00, 1'b0, 2); check("fill_count2", 64'(count), 64'(2));
      step(2'b11, 32'h08, 2'b00, 1'b0, 2); check("fill_count4", 64'(count), 64'(4));
      step(2'b11, 32'h10, 2'b00, 1'b0, 2); check("fill_count6", 64'(count), 64'(6));
      check("fill_ready6", 64'(enq_ready), 64'(1));
      step(2'b11, 32'h18, 2'b00, 1'b0, 2); check("fill_count8", 64'(count), 64'(8));
      check("full_ready", 64'(enq_ready), 64'(0));
      step(2'b11, 32'h100, 2'b00, 1'b0, 0); check("full_ignored", 64'(count), 64'(8));

      // Drain in pairs
      step(2'b00, 32'h0, 2'b11, 1'b0, 0); check("drain_count6", 64'(count), 64'(6));
      step(2'b00, 32'h0, 2'b11, 1'b0, 0); check("drain_count4", 64'(count), 64'(4));
      step(2'b00, 32'h0, 2'b11, 1'b0, 0); check("drain_count2", 64'(count), 64'(2));
      step(2'b00, 32'h0, 2'b11, 1'b0, 0); check("drain_count0", 64'(count), 64'(0));
      check("drain_valid", 64'(deq_valid), 64'(0));
      check("drain_inst", deq_inst, {NOP_INST, NOP_INST});
      check("drain_pc", deq_pc, 64'(0));

      // Simultaneous enqueue and dequeue at count 3
      step(2'b11, 32'h300, 2'b00, 1'b0, 2);
      step(2'b01, 32'h308, 2'b00, 1'b0, 1); check("mix_count3", 64'(count), 64'(3));
      step(2'b11, 32'h30C, 2'b01, 1'b0, 2); check("mix_count4", 64'(count), 64'(4));
      check("mix_slot0", 64'(deq_pc[31:0]), 64'(32'h304));
      step(2'b00, 32'h0, 2'b11, 1'b0, 0);
      step(2'b00, 32'h0, 2'b11, 1'b0, 0); check("mix_empty", 64'(count), 64'(0));

      // Steady stream across the wrap point
      step(2'b11, 32'h400, 2'b00, 1'b0, 2);
      for (int i = 0; i < 20; i++) step(2'b11, 32'h408 + 32'(8 * i), 2'b11, 1'b0, 2);
      check("wrap_count", 64'(count), 64'(2));
      check("wrap_slot0", 64'(deq_pc[31:0]), 64'(32'h4A0));
      step(2'b00, 32'h0, 2'b11, 1'b0, 0); check("wrap_empty", 64'(count), 64'(0));

      // Almost-full boundary, then flush with count 6
      step(2'b11, 32'h500, 2'b00, 1'b0, 2);
      step(2'b11, 32'h508, 2'b00, 1'b0, 2);
      step(2'b11, 32'h510, 2'b00, 1'b0, 2);
      step(2'b01, 32'h518, 2'b00, 1'b0, 1); check("af_count7", 64'(count), 64'(7));
      check("af_ready7", 64'(enq_ready), 64'(0));
      step(2'b00, 32'h0, 2'b01, 1'b0, 0); check("af_count6", 64'(count), 64'(6));
      check("af_ready6", 64'(enq_ready), 64'(1));
      step(2'b11, 32'h600, 2'b00, 1'b1, 0);
      check("flush_count", 64'(count), 64'(0));
      check("flush_valid", 64'(deq_valid), 64'(0));
      step(2'b11, 32'h700, 2'b00, 1'b0, 2);
      check("post_flush_pc", 64'(deq_pc[31:0]), 64'(32'h700));
      step(2'b00, 32'h0, 2'b11, 1'b0, 0); check("post_flush_empty", 64'(count), 64'(0));

      // Protocol violations
      step(2'b01, 32'h800, 2'b00, 1'b0, 1); check("pv_count1", 64'(count), 64'(1));
      check("pv_err_idle", 64'(err), 64'(0));
      step(2'b10, 32'h900, 2'b00, 1'b0, 0);
      check("pv_enq_err", 64'(err), 64'(1));
      check("pv_enq_count", 64'(count), 64'(1));
      step(2'b00, 32'h0, 2'b00, 1'b0, 0);
      check("pv_err_clear1", 64'(err), 64'(0));
      step(2'b00, 32'h0, 2'b11, 1'b0, 0);
      check("pv_deq_err", 64'(err), 64'(1));
      check("pv_deq_count", 64'(count), 64'(1));
      step(2'b00, 32'h0, 2'b00, 1'b0, 0);
      check("pv_err_clear2", 64'(err), 64'(0));
      step(2'b00, 32'h0, 2'b01, 1'b0, 0); check("pv_empty", 64'(count), 64'(0));

      step(2'b00, 32'h0, 2'b00, 1'b0, 0);
      check("sb_empty", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
